hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It produces the forwarding selects consumed by the execute stage (`ForwardAE`/`ForwardBE`: 00 register file, 01 `ResultW`, 10 `ALUResultM`), plus per-stage stall and flush controls. It sequences multi-cycle data-memory waits with a small state machine and a wait-timeout counter. It sits beside the stage registers and observes register indices and control bits from decode, execute, memory and writeback.

## Interface
Parameters:
- `MAX_WAIT`, 16: memory-wait cycles tolerated before timeout is flagged.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `Rs1D_i`, `Rs2D_i`  in  5  source registers of the instruction in decode.
- `Rs1E_i`, `Rs2E_i`  in  5  source registers of the instruction in execute.
- `RdE_i`  in  5  destination register in execute; `RegWriteE_i`  in  1; `WriteSrcE_i`  in  2 (2'b01 = load result).
- `RdM_i`  in  5  destination register in memory; `RegWriteM_i`  in  1.
- `RdW_i`  in  5  destination register in writeback; `RegWriteW_i`  in  1.
- `Redirect_i`  in  1  branch/jump/return taken, resolved in memory stage.
- `MemReq_i`  in  1  memory stage has an access in flight; `MemReady_i`  in  1  access completes this cycle.
- `ForwardAE_o`, `ForwardBE_o`  out  2  execute operand A/B select.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o`  out  1  hold the PC / stage register.
- `FlushD_o`, `FlushE_o`, `FlushM_o`  out  1  clear the stage register to a bubble.
- `MemTimeout_o`  out  1  sticky; memory wait exceeded `MAX_WAIT`.
- `StallCycles_o`, `FlushCount_o`  out  `CNT_W`  performance counters (macro-dependent, see Configuration).

## Operation
- **Forwarding** (per operand, with X = Rs1E/Rs2E):
  - `RegWriteM_i && RdM_i != 0 && RdM_i == X` gives 10.
  - Otherwise `RegWriteW_i && RdW_i != 0 && RdW_i == X` gives 01.
  - Otherwise 00.
  - Memory-stage match wins over writeback. Register x0 is never forwarded.
- **Load-use**: `RegWriteE_i && WriteSrcE_i == 2'b01 && RdE_i != 0 && (RdE_i == Rs1D_i || RdE_i == Rs2D_i)` asserts `StallF_o`, `StallD_o` and `FlushE_o` for that cycle, inserting one bubble.
- **Redirect**: asserts `FlushD_o`, `FlushE_o` and `FlushM_o` for that cycle. Redirect overrides load-use: the load-use stall is suppressed.
- **FSM** states: RUN, MEM_WAIT.
  - RUN, `MemReq_i && !MemReady_i`: assert all four stalls; go to MEM_WAIT; load the wait counter with 1.
  - RUN, `MemReq_i && MemReady_i`: no stall; stay in RUN.
  - MEM_WAIT, `!MemReady_i`: assert all stalls and all flushes low; `Redirect_i` and load-use are masked; wait counter increments, saturating at `MAX_WAIT`.
  - MEM_WAIT, `MemReady_i`: stalls released this cycle; `Redirect_i` and load-use are evaluated normally; go to RUN.
  - Wait counter reaching `MAX_WAIT` while still in MEM_WAIT sets `MemTimeout_o`. It clears only on reset.
- **Priority** within a cycle: reset, then memory stall, then redirect, then load-use.

## Timing
- Forward, stall and flush outputs are combinational from inputs and the current state, with zero latency.
- State, wait counter, timeout and performance counters are registered and update at the rising edge.
- While `rst_ni` is low:
  - Forwards are 00; all stalls are 0.
  - `FlushD_o`, `FlushE_o`, `FlushM_o` are 1.
  - At the edge, state becomes RUN, wait counter 0, `MemTimeout_o` 0, counters 0.
- Reset asserted during MEM_WAIT aborts the wait; stalls drop the same cycle.
- The load-use bubble costs exactly 1 cycle.
- A memory wait whose ready arrives N cycles after the request costs N stall cycles.

## Configuration
- Macro: `HAZARD_PERF_CNT_EN`.
- **Defined**:
  - `StallCycles_o` increments on every cycle in which `StallF_o` is 1.
  - `FlushCount_o` increments on every cycle in which `FlushE_o` is 1 while `rst_ni` is high.
  - Both counters wrap modulo 2^`CNT_W`.
- **Undefined**: both outputs are tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- Forwarding priority:
  - Rs1E=5, RdM=5/RegWriteM=1, RdW=5/RegWriteW=1 → `ForwardAE_o`=10.
  - RegWriteM=0 → 01.
  - Rs1E=0 with RdM=0 → 00.
- Load-use: RdE=7, WriteSrcE=01, RegWriteE=1, Rs2D=7 → StallF=StallD=FlushE=1 for one cycle; next cycle (RdE cleared) all 0.
- Redirect plus load-use in the same cycle → FlushD/E/M=1, StallF=StallD=0.
- Memory wait:
  - MemReq=1, MemReady low for 3 cycles then high → stalls high for 3 cycles, low on the ready cycle.
  - State returns to RUN.
  - `StallCycles_o`=3 with the macro defined, 0 without it.
- Timeout: `MAX_WAIT`=4, MemReady held low → `MemTimeout_o` rises after the 4th wait cycle and stays 1 after ready; cleared by `rst_ni`=0.
- Reset mid-wait: `rst_ni`=0 during MEM_WAIT → stalls 0 and flushes 1 immediately; after release, state is RUN and counters are 0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline stage registers and hazard_unit.
// The pipeline drives through the master modport; hazard_unit uses the slave modport.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       Rs1D_i;
    logic [4:0]       Rs2D_i;
    logic [4:0]       Rs1E_i;
    logic [4:0]       Rs2E_i;
    logic [4:0]       RdE_i;
    logic             RegWriteE_i;
    logic [1:0]       WriteSrcE_i;
    logic [4:0]       RdM_i;
    logic             RegWriteM_i;
    logic [4:0]       RdW_i;
    logic             RegWriteW_i;
    logic             Redirect_i;
    logic             MemReq_i;
    logic             MemReady_i;
    logic [1:0]       ForwardAE_o;
    logic [1:0]       ForwardBE_o;
    logic             StallF_o;
    logic             StallD_o;
    logic             StallE_o;
    logic             StallM_o;
    logic             FlushD_o;
    logic             FlushE_o;
    logic             FlushM_o;
    logic             MemTimeout_o;
    logic [CNT_W-1:0] StallCycles_o;
    logic [CNT_W-1:0] FlushCount_o;

    modport master (
        output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RegWriteE_i, WriteSrcE_i,
               RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, Redirect_i, MemReq_i, MemReady_i,
        input  ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushM_o, MemTimeout_o, StallCycles_o, FlushCount_o
    );

    modport slave (
        input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RegWriteE_i, WriteSrcE_i,
               RdM_i, RegWriteM_i, RdW_i, RegWriteW_i, Redirect_i, MemReq_i, MemReady_i,
        output ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
               FlushD_o, FlushE_o, FlushM_o, MemTimeout_o, StallCycles_o, FlushCount_o
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard controller for the five-stage pipeline: operand forwarding, load-use
// bubble, redirect flush and multi-cycle data-memory wait with a sticky timeout.
// Define HAZARD_PERF_CNT_EN to build the stall-cycle and flush performance counters;
// otherwise those outputs are tied to zero.
module hazard_unit #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input logic          clk_i,
    input logic          rst_ni,
    hazard_unit_if.slave bus
);
    // Wide enough to hold MAX_WAIT itself.
    localparam int unsigned WaitW = $clog2(MAX_WAIT + 2);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_m;
    logic       mem_stall;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic rw_m,
                                           input logic [4:0] rd_m, input logic rw_w,
                                           input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && rd_m != 5'd0 && rd_m == rs) begin
            sel = 2'b10;
        end else if (rw_w && rd_w != 5'd0 && rd_w == rs) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // Hazard detection: memory wait is gated by reset so an aborted wait drops stalls at once.
    always_comb begin
        load_use = bus.RegWriteE_i && bus.WriteSrcE_i == 2'b01 && bus.RdE_i != 5'd0 &&
                   (bus.RdE_i == bus.Rs1D_i || bus.RdE_i == bus.Rs2D_i);
        mem_stall = 1'b0;
        if (rst_ni) begin
            if (state_q == StRun) begin
                mem_stall = bus.MemReq_i && !bus.MemReady_i;
            end else begin
                mem_stall = !bus.MemReady_i;
            end
        end
    end

    // Forward/stall/flush outputs; priority is reset, memory stall, redirect, load-use.
    always_comb begin
        fwd_a   = 2'b00;
        fwd_b   = 2'b00;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (!rst_ni) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else begin
            fwd_a = fwd_sel(bus.Rs1E_i, bus.RegWriteM_i, bus.RdM_i, bus.RegWriteW_i, bus.RdW_i);
            fwd_b = fwd_sel(bus.Rs2E_i, bus.RegWriteM_i, bus.RdM_i, bus.RegWriteW_i, bus.RdW_i);
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (bus.Redirect_i) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // Memory-wait FSM next state, saturating wait counter and sticky timeout.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            StRun: begin
                if (bus.MemReq_i && !bus.MemReady_i) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WaitW'(1);
                end
            end
            StMemWait: begin
                if (bus.MemReady_i) begin
                    state_d    = StRun;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q < WaitMax) begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d    = StRun;
                wait_cnt_d = '0;
            end
        endcase
        timeout_d = timeout_q || (state_d == StMemWait && wait_cnt_d >= WaitMax);
    end

    // FSM, wait counter and timeout registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Performance counter increments; both wrap naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + (stall_f ? CNT_W'(1) : CNT_W'(0));
        flush_cnt_d = flush_cnt_q + (flush_e ? CNT_W'(1) : CNT_W'(0));
    end

    // Performance counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.StallCycles_o = stall_cnt_q;
    assign bus.FlushCount_o  = flush_cnt_q;
`else
    assign bus.StallCycles_o = CNT_W'(0);
    assign bus.FlushCount_o  = CNT_W'(0);
`endif

    assign bus.ForwardAE_o  = fwd_a;
    assign bus.ForwardBE_o  = fwd_b;
    assign bus.StallF_o     = stall_f;
    assign bus.StallD_o     = stall_d;
    assign bus.StallE_o     = stall_e;
    assign bus.StallM_o     = stall_m;
    assign bus.FlushD_o     = flush_d;
    assign bus.FlushE_o     = flush_e;
    assign bus.FlushM_o     = flush_m;
    assign bus.MemTimeout_o = timeout_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed test-plan steps followed by random
// stimulus, all checked every cycle against a behavioural model of the pipeline rules.
module tb_hazard_unit;
    localparam int unsigned MW = 4;
    localparam int unsigned CW = 32;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_unit_if #(.CNT_W(CW)) hif ();

    hazard_unit #(
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: whether a memory wait is outstanding, how many stalled
    // wait cycles have elapsed, the sticky timeout and the expected counter totals.
    bit          m_wait;
    int          m_waited;
    bit          m_to;
    longint      m_stalls;
    longint      m_flushes;
    logic [1:0]  e_fa, e_fb;
    logic        e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] x);
        if (hif.RegWriteM_i && hif.RdM_i != 0 && hif.RdM_i == x) return 2'b10;
        if (hif.RegWriteW_i && hif.RdW_i != 0 && hif.RdW_i == x) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_outputs();
        bit waiting, lu;
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm} = '0;
        e_fa = 2'b00;
        e_fb = 2'b00;
        if (!rst_n) begin
            {e_fd, e_fe, e_fm} = 3'b111;
        end else begin
            e_fa = model_fwd(hif.Rs1E_i);
            e_fb = model_fwd(hif.Rs2E_i);
            waiting = m_wait ? !hif.MemReady_i : (hif.MemReq_i && !hif.MemReady_i);
            lu = hif.RegWriteE_i && hif.WriteSrcE_i == 2'b01 && hif.RdE_i != 0 &&
                 (hif.RdE_i == hif.Rs1D_i || hif.RdE_i == hif.Rs2D_i);
            if (waiting) {e_sf, e_sd, e_se, e_sm} = 4'b1111;
            else if (hif.Redirect_i) {e_fd, e_fe, e_fm} = 3'b111;
            else if (lu) {e_sf, e_sd, e_fe} = 3'b111;
        end
    endtask

    task automatic model_advance();
        if (!rst_n) begin
            m_wait = 0;
            m_waited = 0;
            m_to = 0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            m_stalls += e_sf;
            m_flushes += e_fe;
            // A stalled memory cycle means the access is still outstanding next cycle.
            if (e_sm) begin
                m_wait = 1;
                m_waited++;
                if (m_waited >= MW) m_to = 1;
            end else begin
                m_wait = 0;
                m_waited = 0;
            end
        end
    endtask

    // One clock: settle, compare every output with the model, advance past the edge.
    task automatic cycle(input string tag);
        #1;
        model_outputs();
        check({tag, ".fa"}, 32'(hif.ForwardAE_o), 32'(e_fa));
        check({tag, ".fb"}, 32'(hif.ForwardBE_o), 32'(e_fb));
        check({tag, ".stall"}, 32'({hif.StallF_o, hif.StallD_o, hif.StallE_o, hif.StallM_o}),
              32'({e_sf, e_sd, e_se, e_sm}));
        check({tag, ".flush"}, 32'({hif.FlushD_o, hif.FlushE_o, hif.FlushM_o}),
              32'({e_fd, e_fe, e_fm}));
        check({tag, ".timeout"}, 32'(hif.MemTimeout_o), 32'(m_to));
`ifdef HAZARD_PERF_CNT_EN
        check({tag, ".stallcnt"}, hif.StallCycles_o, 32'(m_stalls));
        check({tag, ".flushcnt"}, hif.FlushCount_o, 32'(m_flushes));
`else
        check({tag, ".stallcnt"}, hif.StallCycles_o, 32'd0);
        check({tag, ".flushcnt"}, hif.FlushCount_o, 32'd0);
`endif
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hif.Rs1D_i = 0; hif.Rs2D_i = 0; hif.Rs1E_i = 0; hif.Rs2E_i = 0;
        hif.RdE_i = 0; hif.RegWriteE_i = 0; hif.WriteSrcE_i = 0;
        hif.RdM_i = 0; hif.RegWriteM_i = 0; hif.RdW_i = 0; hif.RegWriteW_i = 0;
        hif.Redirect_i = 0; hif.MemReq_i = 0; hif.MemReady_i = 0;
    endtask

    initial begin
        longint stalls_before;
        m_wait = 0; m_waited = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        #1;
        cycle("reset0");
        hif.MemReq_i = 1;
        cycle("reset1");
        rst_n = 1'b1;
        idle_inputs();
        cycle("idle");

        // Forwarding priority.
        hif.Rs1E_i = 5; hif.Rs2E_i = 5;
        hif.RdM_i = 5; hif.RegWriteM_i = 1; hif.RdW_i = 5; hif.RegWriteW_i = 1;
        #1;
        check("fwd_mem_wins", 32'(hif.ForwardAE_o), 32'd2);
        cycle("fwd_mw");
        hif.RegWriteM_i = 0;
        #1;
        check("fwd_wb", 32'(hif.ForwardAE_o), 32'd1);
        cycle("fwd_w");
        hif.Rs1E_i = 0; hif.RdM_i = 0; hif.RegWriteM_i = 1; hif.RdW_i = 0;
        #1;
        check("fwd_x0", 32'(hif.ForwardAE_o), 32'd0);
        cycle("fwd_x0");

        // Load-use bubble lasts one cycle.
        idle_inputs();
        hif.RdE_i = 7; hif.WriteSrcE_i = 2'b01; hif.RegWriteE_i = 1; hif.Rs2D_i = 7;
        #1;
        check("lu_bubble", 32'({hif.StallF_o, hif.StallD_o, hif.FlushE_o}), 32'd7);
        cycle("lu");
        hif.RdE_i = 0;
        cycle("lu_after");

        // Redirect beats load-use.
        hif.RdE_i = 7; hif.Redirect_i = 1;
        #1;
        check("redir_over_lu",
              32'({hif.FlushD_o, hif.FlushE_o, hif.FlushM_o, hif.StallF_o, hif.StallD_o}),
              32'b11100);
        cycle("redir_lu");

        // Three-cycle memory wait.
        idle_inputs();
        stalls_before = m_stalls;
        hif.MemReq_i = 1;
        for (int i = 0; i < 3; i++) cycle("memwait");
        hif.MemReady_i = 1;
        cycle("memready");
        hif.MemReq_i = 0;
        hif.MemReady_i = 0;
        cycle("mem_run");
        check("mem_stall_cost", 32'(m_stalls - stalls_before), 32'd3);

        // Timeout: sticky after the MAX_WAIT-th wait cycle, cleared only by reset.
        hif.MemReq_i = 1;
        for (int i = 0; i < MW + 1; i++) cycle("to_wait");
        hif.MemReady_i = 1;
        cycle("to_ready");
        hif.MemReq_i = 0;
        hif.MemReady_i = 0;
        cycle("to_sticky");
        check("to_stays", 32'(hif.MemTimeout_o), 32'd1);
        rst_n = 0;
        cycle("to_reset");
        rst_n = 1;
        cycle("to_cleared");

        // Reset in the middle of a wait.
        hif.MemReq_i = 1;
        cycle("rw_enter");
        cycle("rw_wait");
        rst_n = 0;
        #1;
        check("rw_abort", 32'({hif.StallF_o, hif.StallM_o, hif.FlushD_o, hif.FlushE_o}),
              32'b0011);
        cycle("rw_reset");
        rst_n = 1;
        hif.MemReq_i = 0;
        cycle("rw_run");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            hif.Rs1D_i = 5'($urandom_range(0, 7));
            hif.Rs2D_i = 5'($urandom_range(0, 7));
            hif.Rs1E_i = 5'($urandom_range(0, 7));
            hif.Rs2E_i = 5'($urandom_range(0, 7));
            hif.RdE_i = 5'($urandom_range(0, 7));
            hif.RegWriteE_i = 1'($urandom);
            hif.WriteSrcE_i = 2'($urandom);
            hif.RdM_i = 5'($urandom_range(0, 7));
            hif.RegWriteM_i = 1'($urandom);
            hif.RdW_i = 5'($urandom_range(0, 7));
            hif.RegWriteW_i = 1'($urandom);
            hif.Redirect_i = ($urandom_range(0, 5) == 0);
            hif.MemReq_i = ($urandom_range(0, 2) == 0);
            hif.MemReady_i = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
